// File: rtl/cache_axi_pkg.sv
// Shared AXI3 codes, FSM encoding and helpers for the cache line engine.
// Optional feature macro: CACHE_ENG_CWF_EN (critical-word-first fills).
package cache_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] PROT_DFLT  = 3'b010;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R    = 3'd2;
    localparam logic [2:0] ST_AW   = 3'd3;
    localparam logic [2:0] ST_W    = 3'd4;
    localparam logic [2:0] ST_B    = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    function automatic logic [2:0] size_from_width(input int width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/line_beat_ctr.sv
// Beat counter shared by the R and W phases of a line burst.
// Cleared only at completion, so it never wraps mid-burst.
module line_beat_ctr #(
    parameter int LINE_WORDS = 16,
    localparam int CW = $clog2(LINE_WORDS)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          enable,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          is_last
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign is_last = (count == CW'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_line_axi_engine.sv
// AXI3 line fill / write-back master with response and beat-count checking.
// Define CACHE_ENG_CWF_EN for critical-word-first WRAP fills.
module cache_line_axi_engine
    import cache_axi_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter int         LINE_WORDS = 16,
    parameter int         ADDR_W     = 32,
    parameter logic [5:0] AXI_ID     = 6'h0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  fill_valid,
    output logic                  fill_last,
    input  logic                  fill_ready,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    output logic                  done,
    output logic                  done_err,
    output logic                  cm_arvalid,
    input  logic                  cm_arready,
    output logic [5:0]            cm_arid,
    output logic [ADDR_W-1:0]     cm_araddr,
    output logic [3:0]            cm_arlen,
    output logic [2:0]            cm_arsize,
    output logic [1:0]            cm_arburst,
    output logic [1:0]            cm_arlock,
    output logic [3:0]            cm_arcache,
    output logic [2:0]            cm_arprot,
    input  logic                  mc_rvalid,
    output logic                  mc_rready,
    input  logic [DATA_W-1:0]     mc_rdata,
    input  logic [5:0]            mc_rid,
    input  logic [1:0]            mc_rresp,
    input  logic                  mc_rlast,
    output logic                  cm_awvalid,
    input  logic                  cm_awready,
    output logic [5:0]            cm_awid,
    output logic [ADDR_W-1:0]     cm_awaddr,
    output logic [3:0]            cm_awlen,
    output logic [2:0]            cm_awsize,
    output logic [1:0]            cm_awburst,
    output logic [1:0]            cm_awlock,
    output logic [3:0]            cm_awcache,
    output logic [2:0]            cm_awprot,
    output logic [5:0]            cm_wid,
    output logic [DATA_W-1:0]     cm_wdata,
    output logic [DATA_W/8-1:0]   cm_wstrb,
    output logic                  cm_wlast,
    output logic                  cm_wvalid,
    input  logic                  cm_wready,
    input  logic                  mc_bvalid,
    output logic                  mc_bready,
    input  logic [5:0]            mc_bid,
    input  logic [1:0]            mc_bresp
);

    localparam int CW    = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_W / 8);
    localparam int WRD_W = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

    logic [2:0]        state, nxt;
    logic [ADDR_W-1:0] ax_addr, fill_addr;
    logic [1:0]        ax_burst, fill_burst;
    logic [3:0]        ax_len;
    logic [2:0]        ax_size, ax_prot;
    logic              err, accept;
    logic              r_beat, w_beat, b_hit, r_bad, b_bad;
    logic [CW-1:0]     count;
    logic              is_last;

`ifdef CACHE_ENG_CWF_EN
    localparam logic [ADDR_W-1:0] WORD_MASK =
        ~((ADDR_W'(1) << WRD_W) - ADDR_W'(1));
    assign fill_addr  = req_addr & WORD_MASK;
    assign fill_burst = BURST_WRAP;
`else
    assign fill_addr  = req_addr & LINE_MASK;
    assign fill_burst = BURST_INCR;
`endif

    assign accept = (state == ST_IDLE) && req_valid && req_ready;
    assign r_beat = (state == ST_R) && mc_rvalid && fill_ready;
    assign w_beat = (state == ST_W) && wb_valid && cm_wready;
    assign b_hit  = (state == ST_B) && mc_bvalid;
    // rlast is only checked against the local count, never trusted
    assign r_bad  = (mc_rresp != RESP_OKAY) || (mc_rid != AXI_ID) ||
                    (mc_rlast != (count == LAST_IDX));
    assign b_bad  = (mc_bresp != RESP_OKAY) || (mc_bid != AXI_ID);

    line_beat_ctr #(.LINE_WORDS(LINE_WORDS)) u_ctr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .enable  (r_beat || w_beat),
        .clear   (state == ST_DONE),
        .count   (count),
        .is_last (is_last)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: if (accept) nxt = req_write ? ST_AW : ST_AR;
            ST_AR:   if (cm_arready) nxt = ST_R;
            ST_R:    if (r_beat && is_last) nxt = ST_DONE;
            ST_AW:   if (cm_awready) nxt = ST_W;
            ST_W:    if (w_beat && is_last) nxt = ST_B;
            ST_B:    if (b_hit) nxt = ST_DONE;
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            ax_addr   <= '0;
            ax_burst  <= '0;
            ax_len    <= '0;
            ax_size   <= '0;
            ax_prot   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= nxt;
            req_ready <= (nxt == ST_IDLE);
            if (accept) begin
                ax_addr  <= req_write ? (req_addr & LINE_MASK) : fill_addr;
                ax_burst <= req_write ? BURST_INCR : fill_burst;
                ax_len   <= 4'(LINE_WORDS - 1);
                ax_size  <= size_from_width(DATA_W);
                ax_prot  <= PROT_DFLT;
            end
            if (state == ST_DONE) begin
                err <= 1'b0;
            end else if ((r_beat && r_bad) || (b_hit && b_bad)) begin
                err <= 1'b1;
            end
        end
    end

    assign done       = (state == ST_DONE);
    assign done_err   = done && err;

    assign cm_arvalid = (state == ST_AR);
    assign cm_arid    = AXI_ID;
    assign cm_araddr  = ax_addr;
    assign cm_arlen   = ax_len;
    assign cm_arsize  = ax_size;
    assign cm_arburst = ax_burst;
    assign cm_arlock  = 2'b00;
    assign cm_arcache = 4'b0000;
    assign cm_arprot  = ax_prot;

    assign mc_rready  = (state == ST_R) && fill_ready;
    assign fill_valid = (state == ST_R) && mc_rvalid;
    assign fill_data  = mc_rdata;
    assign fill_last  = (state == ST_R) && is_last;

    assign cm_awvalid = (state == ST_AW);
    assign cm_awid    = AXI_ID;
    assign cm_awaddr  = ax_addr;
    assign cm_awlen   = ax_len;
    assign cm_awsize  = ax_size;
    assign cm_awburst = ax_burst;
    assign cm_awlock  = 2'b00;
    assign cm_awcache = 4'b0000;
    assign cm_awprot  = ax_prot;

    assign cm_wid     = AXI_ID;
    assign cm_wdata   = wb_data;
    assign cm_wstrb   = '1;
    assign cm_wvalid  = (state == ST_W) && wb_valid;
    assign cm_wlast   = (state == ST_W) && is_last;
    assign wb_ready   = (state == ST_W) && cm_wready;

    assign mc_bready  = (state == ST_B);

endmodule

// File: tb/tb_cache_line_axi_engine.sv
// Randomised bench for cache_line_axi_engine with a behavioural line model.
// Honours CACHE_ENG_CWF_EN when computing expected fill addresses.
module tb_cache_line_axi_engine;

    localparam int         DW = 32;
    localparam int         LW = 16;
    localparam int         AW = 32;
    localparam logic [5:0] ID = 6'h05;
    localparam int         LINE_BYTES = LW * DW / 8;

    logic            aclk = 0;
    logic            aresetn = 0;
    logic            req_valid = 0, req_ready, req_write = 0;
    logic [AW-1:0]   req_addr = '0;
    logic [DW-1:0]   fill_data;
    logic            fill_valid, fill_last, fill_ready = 0;
    logic [DW-1:0]   wb_data = '0;
    logic            wb_valid = 0, wb_ready;
    logic            done, done_err;
    logic            cm_arvalid, cm_arready = 0;
    logic [5:0]      cm_arid;
    logic [AW-1:0]   cm_araddr;
    logic [3:0]      cm_arlen, cm_arcache;
    logic [2:0]      cm_arsize, cm_arprot;
    logic [1:0]      cm_arburst, cm_arlock;
    logic            mc_rvalid = 0, mc_rready, mc_rlast = 0;
    logic [DW-1:0]   mc_rdata = '0;
    logic [5:0]      mc_rid = ID;
    logic [1:0]      mc_rresp = 2'b00;
    logic            cm_awvalid, cm_awready = 0;
    logic [5:0]      cm_awid;
    logic [AW-1:0]   cm_awaddr;
    logic [3:0]      cm_awlen, cm_awcache;
    logic [2:0]      cm_awsize, cm_awprot;
    logic [1:0]      cm_awburst, cm_awlock;
    logic [5:0]      cm_wid;
    logic [DW-1:0]   cm_wdata;
    logic [DW/8-1:0] cm_wstrb;
    logic            cm_wlast, cm_wvalid, cm_wready = 0;
    logic            mc_bvalid = 0, mc_bready;
    logic [5:0]      mc_bid = ID;
    logic [1:0]      mc_bresp = 2'b00;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] beat_d [LW];
    logic [AW-1:0] seen_addr;
    logic [1:0]    seen_burst;

    always #5 aclk = ~aclk;

    cache_line_axi_engine #(
        .DATA_W(DW), .LINE_WORDS(LW), .ADDR_W(AW), .AXI_ID(ID)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .fill_data(fill_data), .fill_valid(fill_valid),
        .fill_last(fill_last), .fill_ready(fill_ready),
        .wb_data(wb_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .done(done), .done_err(done_err),
        .cm_arvalid(cm_arvalid), .cm_arready(cm_arready),
        .cm_arid(cm_arid), .cm_araddr(cm_araddr), .cm_arlen(cm_arlen),
        .cm_arsize(cm_arsize), .cm_arburst(cm_arburst),
        .cm_arlock(cm_arlock), .cm_arcache(cm_arcache),
        .cm_arprot(cm_arprot),
        .mc_rvalid(mc_rvalid), .mc_rready(mc_rready),
        .mc_rdata(mc_rdata), .mc_rid(mc_rid), .mc_rresp(mc_rresp),
        .mc_rlast(mc_rlast),
        .cm_awvalid(cm_awvalid), .cm_awready(cm_awready),
        .cm_awid(cm_awid), .cm_awaddr(cm_awaddr), .cm_awlen(cm_awlen),
        .cm_awsize(cm_awsize), .cm_awburst(cm_awburst),
        .cm_awlock(cm_awlock), .cm_awcache(cm_awcache),
        .cm_awprot(cm_awprot),
        .cm_wid(cm_wid), .cm_wdata(cm_wdata), .cm_wstrb(cm_wstrb),
        .cm_wlast(cm_wlast), .cm_wvalid(cm_wvalid),
        .cm_wready(cm_wready),
        .mc_bvalid(mc_bvalid), .mc_bready(mc_bready),
        .mc_bid(mc_bid), .mc_bresp(mc_bresp)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input bit wr,
                                               input logic [AW-1:0] a);
`ifdef CACHE_ENG_CWF_EN
        if (!wr) return a & ~AW'(DW / 8 - 1);
`endif
        return a & ~AW'(LINE_BYTES - 1);
    endfunction

    function automatic logic [1:0] exp_burst(input bit wr);
`ifdef CACHE_ENG_CWF_EN
        if (!wr) return 2'b10;
`endif
        return 2'b01;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_arvalid"}, cm_arvalid, 0);
        chk({tag, "_awvalid"}, cm_awvalid, 0);
        chk({tag, "_wvalid"}, cm_wvalid, 0);
        chk({tag, "_wlast"}, cm_wlast, 0);
        chk({tag, "_wb_ready"}, wb_ready, 0);
        chk({tag, "_rready"}, mc_rready, 0);
        chk({tag, "_bready"}, mc_bready, 0);
        chk({tag, "_fill_valid"}, fill_valid, 0);
        chk({tag, "_fill_last"}, fill_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_err"}, done_err, 0);
        chk({tag, "_araddr"}, cm_araddr, 0);
        chk({tag, "_awaddr"}, cm_awaddr, 0);
    endtask

    task automatic send_req(input bit wr, input logic [AW-1:0] a);
        req_valid = 1;
        req_write = wr;
        req_addr  = a;
        for (int n = 0; ; n++) begin
            @(negedge aclk);
            if (req_ready) break;
            if (n > 20) begin
                chk("req_ready_timeout", 0, 1);
                break;
            end
            @(posedge aclk);
        end
        @(posedge aclk);
        #1;
        req_valid = 0;
    endtask

    // rst_at >= 0 pulls reset during that write beat and abandons the line
    task automatic txn(input bit wr, input logic [AW-1:0] a, input int mode,
                       input int eb, input bit toggle, input int rst_at);
        bit exp_err;
        bit acc;
        int i, cyc, k;
        for (int j = 0; j < LW; j++) beat_d[j] = $urandom;
        exp_err = wr ? (mode == 1 || mode == 4) : (mode != 0);
        send_req(wr, a);
        k = $urandom_range(0, 3);
        for (int c = 0; c <= k; c++) begin
            if (wr) begin
                cm_awready = (c == k);
                wb_valid = 1;
            end else begin
                cm_arready = (c == k);
            end
            @(negedge aclk);
            if (wr) begin
                chk("awvalid", cm_awvalid, 1);
                chk("awaddr", cm_awaddr, exp_addr(1, a));
                chk("awlen", cm_awlen, LW - 1);
                chk("awsize", cm_awsize, $clog2(DW / 8));
                chk("awburst", cm_awburst, exp_burst(1));
                chk("awprot", cm_awprot, 3'b010);
                chk("awid", cm_awid, ID);
                chk("awlock_cache", {cm_awlock, cm_awcache}, 0);
                chk("w_before_aw", cm_wvalid, 0);
                chk("wbrdy_before_aw", wb_ready, 0);
                seen_addr  = cm_awaddr;
                seen_burst = cm_awburst;
            end else begin
                chk("arvalid", cm_arvalid, 1);
                chk("araddr", cm_araddr, exp_addr(0, a));
                chk("arlen", cm_arlen, LW - 1);
                chk("arsize", cm_arsize, $clog2(DW / 8));
                chk("arburst", cm_arburst, exp_burst(0));
                chk("arprot", cm_arprot, 3'b010);
                chk("arid", cm_arid, ID);
                chk("arlock_cache", {cm_arlock, cm_arcache}, 0);
                seen_addr  = cm_araddr;
                seen_burst = cm_arburst;
            end
            @(posedge aclk);
            #1;
        end
        cm_arready = 0;
        cm_awready = 0;
        wb_valid   = 0;
        i = 0;
        cyc = 0;
        while (i < LW && cyc < 1000) begin
            if (wr) begin
                wb_valid  = ($urandom_range(0, 3) != 0);
                wb_data   = beat_d[i];
                cm_wready = toggle ? cyc[0] : ($urandom_range(0, 3) != 0);
                if (i == rst_at) begin
                    #1 aresetn = 0;
                    #1;
                    chk_idle_outputs("rst_mid_w");
                    wb_valid  = 0;
                    cm_wready = 0;
                    @(posedge aclk);
                    #1 aresetn = 1;
                    return;
                end
                @(negedge aclk);
                chk("wvalid", cm_wvalid, wb_valid);
                chk("wb_ready", wb_ready, cm_wready);
                chk("wlast", cm_wlast, (i == LW - 1));
                chk("wstrb", cm_wstrb, {(DW / 8){1'b1}});
                chk("wid", cm_wid, ID);
                if (cm_wvalid) chk("wdata", cm_wdata, beat_d[i]);
                chk("done_in_w", done, 0);
                acc = wb_valid && cm_wready;
            end else begin
                mc_rvalid  = ($urandom_range(0, 3) != 0);
                fill_ready = ($urandom_range(0, 3) != 0);
                mc_rdata   = beat_d[i];
                mc_rresp   = (mode == 1 && i == eb) ? 2'b10 : 2'b00;
                mc_rid     = (mode == 4 && i == eb) ? (ID ^ 6'h01) : ID;
                mc_rlast   = (mode == 2) ? (i == eb) :
                             (mode == 3) ? 1'b0 : (i == LW - 1);
                @(negedge aclk);
                chk("fill_valid", fill_valid, mc_rvalid);
                chk("rready", mc_rready, fill_ready);
                chk("fill_last", fill_last, (i == LW - 1));
                if (fill_valid) chk("fill_data", fill_data, beat_d[i]);
                chk("done_in_r", done, 0);
                acc = mc_rvalid && fill_ready;
            end
            @(posedge aclk);
            #1;
            if (acc) i++;
            cyc++;
        end
        if (i < LW) chk("beat_timeout", i, LW);
        mc_rvalid = 0;
        fill_ready = 0;
        wb_valid = 0;
        cm_wready = 0;
        if (wr) begin
            k = $urandom_range(0, 3);
            for (int c = 0; c <= k; c++) begin
                mc_bvalid = (c == k);
                mc_bresp  = (mode == 1) ? 2'b10 : 2'b00;
                mc_bid    = (mode == 4) ? (ID ^ 6'h02) : ID;
                @(negedge aclk);
                chk("bready", mc_bready, 1);
                chk("done_in_b", done, 0);
                @(posedge aclk);
                #1;
            end
            mc_bvalid = 0;
            mc_bresp  = 2'b00;
            mc_bid    = ID;
        end
        @(negedge aclk);
        chk("done", done, 1);
        chk("done_err", done_err, exp_err);
        chk("req_ready_in_done", req_ready, 0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("done_pulse", done, 0);
        chk("req_ready_idle", req_ready, 1);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk_idle_outputs("reset");
        @(posedge aclk);
        #1 aresetn = 1;

        txn(0, 32'h1234_5678, 0, 0, 0, -1);
`ifdef CACHE_ENG_CWF_EN
        chk("lit_fill_addr", seen_addr, 32'h1234_5678);
        chk("lit_fill_burst", seen_burst, 2'b10);
`else
        chk("lit_fill_addr", seen_addr, 32'h1234_5640);
        chk("lit_fill_burst", seen_burst, 2'b01);
`endif
        txn(1, 32'h0000_1000, 0, 0, 1, -1);
        chk("lit_wb_addr", seen_addr, 32'h0000_1000);
        chk("lit_wb_burst", seen_burst, 2'b01);
        txn(0, 32'h0000_2040, 1, 2, 0, -1);
        txn(0, 32'h0000_3000, 2, 7, 0, -1);
        txn(0, 32'h0000_100C, 0, 0, 0, -1);
`ifdef CACHE_ENG_CWF_EN
        chk("lit_cwf_addr", seen_addr, 32'h0000_100C);
        chk("lit_cwf_burst", seen_burst, 2'b10);
`else
        chk("lit_cwf_addr", seen_addr, 32'h0000_1000);
        chk("lit_cwf_burst", seen_burst, 2'b01);
`endif
        txn(1, 32'h0000_5000, 0, 0, 0, 4);
        txn(0, 32'h0000_6010, 0, 0, 0, -1);

        for (int t = 0; t < 25; t++) begin
            bit wr;
            int mode;
            wr = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            txn(wr, $urandom, mode, $urandom_range(0, LW - 2),
                1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_line_axi_engine.md
# cache_line_axi_engine

Parametrised AXI3 master for cache line fill and write-back, used between the cache controller core and the memory controller, entirely in the aclk domain. Accepts one line request at a time (fill or write-back), issues one burst of LINE_WORDS beats, streams fill data out and write-back data in with full back-pressure, and reports completion with a sticky error flag. It generalises the earlier fixed 32-bit, 16-beat engine to configurable data width and line length, and adds response checking, beat-count checking and optional critical-word-first fills.

## Interface
- DATA_W, 32: AXI data width; one of 32/64/128.
- LINE_WORDS, 16: beats per cache line; power of two, 2..16 (AXI3 limit).
- ADDR_W, 32: address width.
- AXI_ID, 6'h0: ID driven on AR/AW/W.
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  reset, asynchronous, active-low.
- req_valid / req_ready  in/out  1  line request handshake; ready only in IDLE.
- req_write  in  1  1 = write-back, 0 = fill.
- req_addr  in  ADDR_W  byte address of requested word.
- fill_data / fill_valid / fill_last / fill_ready  out/out/out/in  DATA_W/1/1/1  fill beat stream.
- wb_data / wb_valid / wb_ready  in/in/out  DATA_W/1/1  write-back beat stream.
- done / done_err  out  1/1  one-cycle completion pulse; error qualifier.
- cm_ar*: arvalid, arready(in), arid[5:0], araddr[ADDR_W], arlen[3:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0].
- mc_r*: rvalid(in), rready, rdata[DATA_W](in), rid[5:0](in), rresp[1:0](in), rlast(in).
- cm_aw*: same set as AR; cm_w*: wid[5:0], wdata[DATA_W], wstrb[DATA_W/8], wlast, wvalid, wready(in).
- mc_b*: bvalid(in), bready, bid[5:0](in), bresp[1:0](in).

## Operation
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE: req_ready=1; on req_valid go to AR (req_write=0) or AW (req_write=1); latch address and direction.
- AR/AW: valid held high with stable payload until ready; then R / W.
- Payload: len=LINE_WORDS-1, size=log2(DATA_W/8), lock=0, cache=0, prot=3'b010, id=AXI_ID.
- Address: line-aligned (low log2(LINE_WORDS*DATA_W/8) bits zeroed), burst INCR (2'b01).
- R: mc_rready = fill_ready; fill_valid = mc_rvalid; fill_data = mc_rdata (combinational pass-through).
  - fill_last = (beat counter == LINE_WORDS-1), generated locally, not from rlast.
  - Last local beat accepted → DONE.
- W: cm_wvalid = wb_valid; wb_ready = cm_wready; wdata = wb_data; wstrb all ones; wlast at beat LINE_WORDS-1. Last beat → B.
- B: bready=1; on bvalid → DONE.
- DONE: done=1 for one cycle, done_err = sticky error; clear error and counter; → IDLE.
- Error sources:
  - any rresp/bresp != 2'b00;
  - rlast on a beat other than LINE_WORDS-1, or missing on that beat;
  - rid/bid != AXI_ID.
- Errors never abort the burst; all LINE_WORDS beats are still consumed.

## Timing
- Reset: all valids, readies, done, done_err, fill_last, wlast = 0; payload registers = 0; state IDLE.
- Request accepted in cycle N → cm_arvalid/cm_awvalid high in cycle N+1 (registered).
- Earliest fill: one request cycle + one AR cycle + LINE_WORDS beats + one DONE cycle.
- Earliest write-back: one request cycle + one AW cycle + LINE_WORDS beats + ≥1 B cycle + one DONE cycle.
- W never starts before AW is accepted.
- Data paths add zero latency; back-pressure from either side stalls the counter.
- Counter width is log2(LINE_WORDS); it wraps only via the DONE clear, never mid-burst.
- Reset mid-burst returns to IDLE immediately; no outstanding-transaction recovery.

## Configuration
- CACHE_ENG_CWF_EN defined: fills use WRAP burst (2'b10) with araddr = word-aligned req_addr (critical word first).
  - fill_last still marks the LINE_WORDS-th beat.
  - Write-backs remain INCR, line-aligned.
- Undefined: all bursts INCR, line-aligned.

## Structure
- Package cache_axi_pkg holds:
  - burst codes (INCR, WRAP);
  - resp OKAY;
  - prot default 3'b010;
  - state encoding;
  - the size-from-width function.
- Sub-module line_beat_ctr: enable, clear, count, is_last; used for both R and W.

## Test plan
- Fill, DATA_W=32, LINE_WORDS=16, req_addr 0x1234_5678 → araddr 0x1234_5640, arlen 15, arsize 2; 16 beats out, fill_last on beat 16; done=1, done_err=0.
- Write-back of 0x0000_1000 with cm_wready toggled every other cycle → wlast on beat 16 only; bresp OKAY → done_err=0.
- Fill with rresp=2'b10 on beat 3 → all 16 beats still forwarded; done_err=1.
- rlast asserted on beat 8 of 16 → done_err=1; engine waits for beat 16, then returns to IDLE.
- CACHE_ENG_CWF_EN, req_addr 0x100C → araddr 0x100C, arburst 2'b10; undefined build → araddr 0x1000, arburst 2'b01.
- aresetn asserted during W beat 5 → all outputs 0 next edge; new fill then completes normally.
